ysyx_24100029_axi_arbiter: RTL
==============================

YSYX_24100029_AXI_ARBITER -- requirements
Module: ysyx_24100029_axi_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all AR/AW channels.
REQ-002 Parameter DATA_W, 32, data width of R/W channels.
REQ-003 Parameter ID_W, 4, width of all id fields.
REQ-004 clock  input  1  clock; all state updates on posedge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 m0_ar{valid,addr,id,len,size,burst}  input  1/ADDR_W/ID_W/8/3/2  IFU read address; m0_arready output 1.
REQ-007 m0_r{valid,data,resp,last,id}  output  1/DATA_W/2/1/ID_W  IFU read data; m0_rready input 1.
REQ-008 m1_ar*/m1_r*  same widths and directions as m0  LSU read channels.
REQ-009 m1_aw{valid,addr,id,len,size,burst}, m1_w{valid,data,strb,last}  input  LSU write address/data; m1_awready, m1_wready output 1.
REQ-010 m1_b{valid,resp,id}  output  LSU write response; m1_bready input 1.
REQ-011 s_ar*, s_aw*, s_w*  output; s_arready, s_awready, s_wready input  slave-side channels, mirrored widths.
REQ-012 s_r*, s_b*  input; s_rready, s_bready output  slave-side responses.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Registered FSM states: IDLE, RD0 (IFU read), RD1 (LSU read), WR (LSU write).
REQ-015 IDLE priority, evaluated each cycle: m1_awvalid -> WR; else m1_arvalid -> RD1; else m0_arvalid -> RD0; else stay.
REQ-016 Grant takes effect the cycle after the request is seen; no slave valid is driven while in IDLE.
REQ-017 RDx: s_ar* = mx_ar*; s_arvalid = mx_arvalid & ~ar_done; mx_arready = s_arready & ~ar_done; ar_done set on the s_ar handshake and cleared on leaving RDx.
REQ-018 RDx: s_r* routed to master x; s_rready = mx_rready; the other master sees rvalid=0 and arready=0.
REQ-019 RDx -> IDLE on the cycle of s_rvalid & s_rready & s_rlast; burst len 0..255 supported; grant held for the whole burst.
REQ-020 WR: s_aw*/s_w* = m1_aw*/m1_w*, each gated by its own done flag (aw_done, w_done) as in REQ-017; s_b* routed to m1; exit to IDLE on s_bvalid & s_bready.
REQ-021 Ungranted masters: all ready/valid outputs 0; data/resp outputs 0.
REQ-022 A master's valid asserted while another grant is active is held pending; it is served on a later IDLE pass and never lost.
REQ-023 Response id/resp pass unmodified; SLVERR/DECERR are forwarded and do not alter sequencing.
REQ-024 IDLE to slave handshake: 1 cycle minimum; back-to-back transactions pass through IDLE for exactly 1 cycle.

Reset
REQ-025 On reset: state=IDLE, ar_done=aw_done=w_done=0, all valid/ready outputs 0, busy=0.
REQ-026 Reset mid-transaction abandons it; no response is delivered to either master afterwards.

Configuration
REQ-027 Macro YSYX_24100029_AXI_ARB_RR_EN defined: IDLE read selection is round-robin; a 1-bit last_rd register (reset 0 = M0) makes the last-served reader lowest priority; WR keeps top priority.
REQ-028 Macro undefined: fixed priority per REQ-015; last_rd is absent.

Verification
REQ-029 m0_arvalid=1, addr 0x8000_0000, len 0; slave arready at cycle 2, rdata 0xDEAD_BEEF rlast=1 -> m0_rdata=0xDEAD_BEEF, m1_rvalid stays 0, busy drops the cycle after the handshake.
REQ-030 m0_arvalid and m1_arvalid both rise in the same cycle -> RD1 first (fixed); with RR_EN and last_rd=M1 -> RD0 first.
REQ-031 LSU sw to 0x8000_0010, strb 4'b1100, awready 3 cycles before wready -> exactly one s_aw and one s_w handshake, m1_bvalid=1 with bresp 0, then IDLE.
REQ-032 IFU 4-beat burst (len 3) while LSU arvalid is pending -> 4 beats to m0 with only the 4th marked last; LSU served after one IDLE cycle.
REQ-033 reset asserted in RD1 after the AR handshake, before R -> next cycle all outputs 0, state IDLE, late s_rvalid not forwarded.
REQ-034 s_rresp=2'b10 on an LSU read -> m1_rresp=2'b10, FSM returns to IDLE normally.

Source files
------------

// File: rtl/ysyx_24100029_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI arbiter with a registered grant FSM.
// Define YSYX_24100029_AXI_ARB_RR_EN to make IDLE read selection round-robin between the two readers.
module ysyx_24100029_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU read master
  input  logic                  m0_arvalid,
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic [ID_W-1:0]       m0_arid,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic [ID_W-1:0]       m0_rid,
  input  logic                  m0_rready,
  // LSU read/write master
  input  logic                  m1_arvalid,
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic [ID_W-1:0]       m1_arid,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic [ID_W-1:0]       m1_rid,
  input  logic                  m1_rready,
  input  logic                  m1_awvalid,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [ID_W-1:0]       m1_awid,
  input  logic [7:0]            m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic [1:0]            m1_awburst,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  output logic [ID_W-1:0]       m1_bid,
  input  logic                  m1_bready,
  // Slave side
  output logic                  s_arvalid,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [ID_W-1:0]       s_arid,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic [ID_W-1:0]       s_rid,
  output logic                  s_rready,
  output logic                  s_awvalid,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [ID_W-1:0]       s_awid,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wlast,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  input  logic [ID_W-1:0]       s_bid,
  output logic                  s_bready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR} state_e;

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   rd_pick_m1;
  logic   ar_hs, r_end, aw_hs, w_end, b_hs;

`ifdef YSYX_24100029_AXI_ARB_RR_EN
  // last_rd_q: 0 = IFU served last, 1 = LSU served last; the last one yields on a tie
  logic last_rd_q, last_rd_d;
  assign rd_pick_m1 = m1_arvalid & (~m0_arvalid | ~last_rd_q);
`else
  assign rd_pick_m1 = m1_arvalid;
`endif

  assign ar_hs = s_arvalid & s_arready;
  assign r_end = s_rvalid & s_rready & s_rlast;
  assign aw_hs = s_awvalid & s_awready;
  assign w_end = s_wvalid & s_wready & s_wlast;
  assign b_hs  = s_bvalid & s_bready;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef YSYX_24100029_AXI_ARB_RR_EN
      last_rd_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef YSYX_24100029_AXI_ARB_RR_EN
      last_rd_q <= last_rd_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef YSYX_24100029_AXI_ARB_RR_EN
    last_rd_d = last_rd_q;
`endif
    case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (m1_awvalid) begin
          state_d = WR;
        end else if (rd_pick_m1) begin
          state_d = RD1;
`ifdef YSYX_24100029_AXI_ARB_RR_EN
          last_rd_d = 1'b1;
`endif
        end else if (m0_arvalid) begin
          state_d = RD0;
`ifdef YSYX_24100029_AXI_ARB_RR_EN
          last_rd_d = 1'b0;
`endif
        end
      end
      RD0, RD1: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_end) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end
      WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        // w_done waits for the last beat so multi-beat writes still stream through
        if (w_end) w_done_d = 1'b1;
        if (b_hs) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    m1_bid     = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    case (state_q)
      RD0: begin
        s_arvalid  = m0_arvalid & ~ar_done_q;
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready & ~ar_done_q;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m0_rid     = s_rid;
        s_rready   = m0_rready;
      end
      RD1: begin
        s_arvalid  = m1_arvalid & ~ar_done_q;
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready & ~ar_done_q;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        m1_rid     = s_rid;
        s_rready   = m1_rready;
      end
      WR: begin
        s_awvalid  = m1_awvalid & ~aw_done_q;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready & ~aw_done_q;
        s_wvalid   = m1_wvalid & ~w_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready & ~w_done_q;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        m1_bid     = s_bid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule
